mat_rd_arbiter: RTL and testbench

- Shares the single read port of the matrix storage between NUM_REQ compute engines, for example the multiplier, adder/scalar unit and display scanner.
- Each engine holds its busy line for a whole operation. The arbiter grants the port to one engine for that entire span, using round-robin selection.
- It muxes the owner's address and control fields to storage and routes returned data and valid back to the owner only.
- A watchdog releases an owner whose storage read never completes.

---
 rtl/mat_rd_arbiter.sv | 154 +++++++++++++++
 tb/tb_mat_rd_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_rd_arbiter.sv
// Round-robin arbiter sharing the matrix storage read port between compute engines.
// An engine owns the port for its whole busy span; a watchdog evicts owners whose read stalls.
module mat_rd_arbiter #(
   parameter int unsigned NUM_REQ     = 3,
   parameter int unsigned DIM_WIDTH   = 3,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned TO_WIDTH    = 8,
   parameter int unsigned TIMEOUT_CYC = 200
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_busy,
   input  logic [NUM_REQ-1:0]           req_rd_en,
   input  logic [NUM_REQ-1:0]           req_slot_idx,
   input  logic [NUM_REQ*DIM_WIDTH-1:0] req_row_idx,
   input  logic [NUM_REQ*DIM_WIDTH-1:0] req_col_idx,
   input  logic [NUM_REQ*DIM_WIDTH-1:0] req_current_m,
   input  logic [NUM_REQ*DIM_WIDTH-1:0] req_current_n,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [DATA_WIDTH-1:0]        req_elem,
   output logic [NUM_REQ-1:0]           req_elem_valid,
   output logic [NUM_REQ-1:0]           req_timeout,
   output logic                         rd_en,
   output logic                         rd_slot_idx,
   output logic [DIM_WIDTH-1:0]         rd_row_idx,
   output logic [DIM_WIDTH-1:0]         rd_col_idx,
   output logic [DIM_WIDTH-1:0]         rd_current_m,
   output logic [DIM_WIDTH-1:0]         rd_current_n,
   input  logic [DATA_WIDTH-1:0]        rd_elem,
   input  logic                         rd_elem_valid,
   output logic                         arb_busy
);

   localparam int unsigned PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned FLD_W = 1 + 4 * DIM_WIDTH;
   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYC - 1);
   localparam logic [TO_WIDTH-1:0] TO_SAT  = {TO_WIDTH{1'b1}};
   localparam logic [NUM_REQ-1:0]  ONE     = NUM_REQ'(1);

   typedef enum logic {S_IDLE, S_OWN} state_t;

   typedef struct packed {
      logic                 slot;
      logic [DIM_WIDTH-1:0] row;
      logic [DIM_WIDTH-1:0] col;
      logic [DIM_WIDTH-1:0] m;
      logic [DIM_WIDTH-1:0] n;
   } rd_fields_t;

   state_t              r_state;
   logic [NUM_REQ-1:0]  r_gnt;
   logic [PTR_W-1:0]    r_owner;
   logic [PTR_W-1:0]    r_last_ptr;
   logic [NUM_REQ-1:0]  r_blocked;
   logic [NUM_REQ-1:0]  r_timeout;
   logic [TO_WIDTH-1:0] r_wdog;

   logic [NUM_REQ-1:0]  w_eligible;
   logic                w_found;
   logic [PTR_W-1:0]    w_pick;
   logic [PTR_W-1:0]    w_idx;
   logic                w_owner_busy;
   logic                w_stall;
   logic                w_expire;
   rd_fields_t          w_fld [NUM_REQ];
   rd_fields_t          w_acc [NUM_REQ+1];

   assign w_eligible   = req_busy & ~r_blocked;
   assign w_owner_busy = |(req_busy & r_gnt);
   assign w_stall      = (r_state == S_OWN) & rd_en & ~rd_elem_valid;
   // The final stalled cycle is the one that would bring the count to TIMEOUT_CYC
   assign w_expire     = w_stall & (r_wdog >= TO_LAST);

   // Round-robin pick: first eligible requester after the previous owner
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         w_idx = PTR_W'((32'(r_last_ptr) + i) % NUM_REQ);
         if (!w_found && w_eligible[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   // AND-OR mux of the owner's address fields; all zero with no owner
   assign w_acc[0] = '0;
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_mux
      assign w_fld[g] = '{slot: req_slot_idx[g],
                          row:  req_row_idx[g*DIM_WIDTH +: DIM_WIDTH],
                          col:  req_col_idx[g*DIM_WIDTH +: DIM_WIDTH],
                          m:    req_current_m[g*DIM_WIDTH +: DIM_WIDTH],
                          n:    req_current_n[g*DIM_WIDTH +: DIM_WIDTH]};
      assign w_acc[g+1] = w_acc[g] | (w_fld[g] & {FLD_W{r_gnt[g]}});
   end

   assign rd_en          = |(req_rd_en & r_gnt);
   assign rd_slot_idx    = w_acc[NUM_REQ].slot;
   assign rd_row_idx     = w_acc[NUM_REQ].row;
   assign rd_col_idx     = w_acc[NUM_REQ].col;
   assign rd_current_m   = w_acc[NUM_REQ].m;
   assign rd_current_n   = w_acc[NUM_REQ].n;

   assign req_elem       = rd_elem;
   assign req_elem_valid = r_gnt & {NUM_REQ{rd_elem_valid & rd_en}};
   assign gnt            = r_gnt;
   assign req_timeout    = r_timeout;
   assign arb_busy       = (r_state == S_OWN);

   // Ownership FSM with watchdog and per-requester timeout lockout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_gnt      <= '0;
         r_owner    <= '0;
         r_last_ptr <= PTR_W'(NUM_REQ - 1);
         r_blocked  <= '0;
         r_timeout  <= '0;
         r_wdog     <= '0;
      end else begin
         r_timeout <= '0;
         r_wdog    <= '0;
         r_blocked <= r_blocked & req_busy;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_gnt   <= ONE << w_pick;
                  r_owner <= w_pick;
                  r_state <= S_OWN;
               end
            end
            S_OWN: begin
               if (!w_owner_busy) begin
                  r_gnt      <= '0;
                  r_last_ptr <= r_owner;
                  r_state    <= S_IDLE;
               end else if (w_expire) begin
                  r_timeout  <= r_gnt;
                  r_blocked  <= (r_blocked & req_busy) | r_gnt;
                  r_gnt      <= '0;
                  r_last_ptr <= r_owner;
                  r_state    <= S_IDLE;
               end else if (w_stall) begin
                  r_wdog <= (r_wdog == TO_SAT) ? r_wdog : r_wdog + TO_WIDTH'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mat_rd_arbiter.sv
// Bench for mat_rd_arbiter: cycle-level ownership model plus directed literal checks.
module tb_mat_rd_arbiter;

   localparam int NR = 3;
   localparam int DW = 3;
   localparam int TO = 200;

   logic             clk;
   logic             rst_n = 1'b0;
   logic [NR-1:0]    req_busy = '0;
   logic [NR-1:0]    rden = '0;
   logic [NR-1:0]    slot = '0;
   logic [DW-1:0]    row [NR];
   logic [DW-1:0]    col [NR];
   logic [DW-1:0]    cm  [NR];
   logic [DW-1:0]    cn  [NR];
   logic [NR*DW-1:0] req_row_idx, req_col_idx, req_current_m, req_current_n;
   logic [7:0]       rd_elem = '0;
   logic             rd_elem_valid = 1'b0;

   logic [NR-1:0]    gnt, req_elem_valid, req_timeout;
   logic [7:0]       req_elem;
   logic             rd_en, rd_slot_idx, arb_busy;
   logic [DW-1:0]    rd_row_idx, rd_col_idx, rd_current_m, rd_current_n;

   int n_chk  = 0;
   int n_pass = 0;
   bit chk_en = 0;

   assign req_row_idx   = {row[2], row[1], row[0]};
   assign req_col_idx   = {col[2], col[1], col[0]};
   assign req_current_m = {cm[2], cm[1], cm[0]};
   assign req_current_n = {cn[2], cn[1], cn[0]};

   mat_rd_arbiter #(.NUM_REQ(NR), .DIM_WIDTH(DW), .DATA_WIDTH(8), .TO_WIDTH(8), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_busy(req_busy), .req_rd_en(rden), .req_slot_idx(slot),
      .req_row_idx(req_row_idx), .req_col_idx(req_col_idx),
      .req_current_m(req_current_m), .req_current_n(req_current_n),
      .gnt(gnt), .req_elem(req_elem), .req_elem_valid(req_elem_valid), .req_timeout(req_timeout),
      .rd_en(rd_en), .rd_slot_idx(rd_slot_idx), .rd_row_idx(rd_row_idx), .rd_col_idx(rd_col_idx),
      .rd_current_m(rd_current_m), .rd_current_n(rd_current_n),
      .rd_elem(rd_elem), .rd_elem_valid(rd_elem_valid), .arb_busy(arb_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Ownership model: owner index (-1 = none), rotating pointer, lockout set, stall run length
   int            m_owner = -1;
   int            m_last  = NR - 1;
   int            m_stall = 0;
   logic [NR-1:0] m_blocked = '0;
   logic [NR-1:0] m_to = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_owner = -1; m_last = NR - 1; m_stall = 0; m_blocked = '0; m_to = '0;
      end else begin
         int nxt;
         bit rdn;
         nxt  = m_owner;
         m_to = '0;
         rdn  = (m_owner >= 0) && rden[m_owner];
         if (m_owner < 0) begin
            for (int k = 1; k <= NR; k++) begin
               int c;
               c = (m_last + k) % NR;
               if (nxt < 0 && req_busy[c] && !m_blocked[c]) nxt = c;
            end
            m_stall = 0;
         end else if (!req_busy[m_owner]) begin
            m_last = m_owner; nxt = -1; m_stall = 0;
         end else if (rdn && !rd_elem_valid) begin
            m_stall++;
            if (m_stall == TO) begin
               m_to[m_owner] = 1'b1; m_last = m_owner; nxt = -1; m_stall = 0;
            end
         end else begin
            m_stall = 0;
         end
         for (int r = 0; r < NR; r++) if (!req_busy[r]) m_blocked[r] = 1'b0;
         m_blocked = m_blocked | m_to;
         m_owner   = nxt;
      end
   end

   // Every-cycle comparison of all DUT outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         logic [NR-1:0] eg, ev;
         logic          er;
         logic [12:0]   ea;
         eg = '0; er = 1'b0; ea = '0;
         if (m_owner >= 0) begin
            eg = NR'(1 << m_owner);
            er = rden[m_owner];
            ea = {slot[m_owner], row[m_owner], col[m_owner], cm[m_owner], cn[m_owner]};
         end
         ev = (er && rd_elem_valid) ? eg : '0;
         chk("gnt", gnt, eg);
         chk("timeout", req_timeout, m_to);
         chk("rd_en", rd_en, er);
         chk("rd_addr", {rd_slot_idx, rd_row_idx, rd_col_idx, rd_current_m, rd_current_n}, ea);
         chk("elem_valid", req_elem_valid, ev);
         chk("elem", req_elem, rd_elem);
         chk("arb_busy", arb_busy, m_owner >= 0);
      end
   end

   initial begin
      for (int r = 0; r < NR; r++) begin
         row[r] = '0; col[r] = '0; cm[r] = '0; cn[r] = '0;
      end
      step(2);
      chk_en = 1;
      @(negedge clk);
      chk("rst_gnt", gnt, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_arb_busy", arb_busy, 0);
      chk("rst_timeout", req_timeout, 0);

      // single requester read
      step(); rst_n = 1'b1;
      step(); req_busy = 3'b001;
      @(negedge clk); chk("t1_gnt_pre", gnt, 3'b000);
      step();
      rden[0] = 1'b1; row[0] = 3'd1; col[0] = 3'd2; cm[0] = 3'd3; cn[0] = 3'd4; slot[0] = 1'b1;
      @(negedge clk);
      chk("t1_gnt", gnt, 3'b001);
      chk("t1_rd_en", rd_en, 1);
      chk("t1_row", rd_row_idx, 1);
      chk("t1_col", rd_col_idx, 2);
      step(); rd_elem = 8'h5A; rd_elem_valid = 1'b1;
      @(negedge clk);
      chk("t1_valid", req_elem_valid, 3'b001);
      chk("t1_elem", req_elem, 8'h5A);
      step(); rden = '0; rd_elem_valid = 1'b0; rd_elem = '0; req_busy = '0;
      step(2);

      // round-robin with every requester busy
      rst_n = 1'b0;
      step(); rst_n = 1'b1;
      for (int c = 0; c <= 16; c++) begin
         logic [NR-1:0] b, eg;
         b = 3'b111;
         if (c % 5 == 4) b[(c / 5) % 3] = 1'b0;
         req_busy = b;
         @(negedge clk);
         eg = (c % 5 == 0) ? 3'b000 : NR'(1 << ((c / 5) % 3));
         chk($sformatf("t2_gnt_c%0d", c), gnt, eg);
         step();
      end
      req_busy = '0;
      step(2);

      // non-owner isolation
      req_busy = 3'b110;
      step();
      rden[2] = 1'b1; row[2] = 3'd7; row[1] = 3'd3; rden[1] = 1'b0;
      @(negedge clk);
      chk("t3_gnt", gnt, 3'b010);
      chk("t3_rd_en", rd_en, 0);
      chk("t3_row", rd_row_idx, 3);
      step(); rd_elem_valid = 1'b1; rd_elem = 8'h11;
      @(negedge clk); chk("t3_valid_blk", req_elem_valid, 3'b000);
      step(); rden[1] = 1'b1; rd_elem = 8'h22;
      @(negedge clk);
      chk("t3_valid_own", req_elem_valid, 3'b010);
      chk("t3_elem", req_elem, 8'h22);
      step(); rden = '0; rd_elem_valid = 1'b0; req_busy = 3'b100;
      step(); @(negedge clk); chk("t3_dead", gnt, 3'b000);
      step(); @(negedge clk); chk("t3_next", gnt, 3'b100);
      step(); req_busy = '0;
      step(2);

      // watchdog timeout and lockout
      req_busy = 3'b011;
      step(); rden[0] = 1'b1;
      @(negedge clk); chk("t4_gnt", gnt, 3'b001);
      step(TO - 1);
      @(negedge clk);
      chk("t4_pre_to", req_timeout, 3'b000);
      chk("t4_pre_gnt", gnt, 3'b001);
      step();
      @(negedge clk);
      chk("t4_to", req_timeout, 3'b001);
      chk("t4_to_gnt", gnt, 3'b000);
      step();
      @(negedge clk);
      chk("t4_to_clr", req_timeout, 3'b000);
      chk("t4_next", gnt, 3'b010);
      step(); req_busy = 3'b001; rden[0] = 1'b0;
      step(); @(negedge clk); chk("t4_blk_a", gnt, 3'b000);
      step(); @(negedge clk); chk("t4_blk_b", gnt, 3'b000);
      step(); req_busy = 3'b000;
      step(); req_busy = 3'b001;
      step(); @(negedge clk); chk("t4_regrant", gnt, 3'b001);

      // busy drop coinciding with timeout
      rden[0] = 1'b1;
      step(TO - 1); req_busy = 3'b000;
      step(); rden[0] = 1'b0;
      @(negedge clk);
      chk("t5a_no_to", req_timeout, 3'b000);
      chk("t5a_gnt", gnt, 3'b000);

      // valid coinciding with timeout
      step(); req_busy = 3'b001;
      step(); rden[0] = 1'b1;
      @(negedge clk); chk("t5b_gnt", gnt, 3'b001);
      step(TO - 1); rd_elem_valid = 1'b1; rd_elem = 8'hC3;
      @(negedge clk);
      chk("t5b_valid", req_elem_valid, 3'b001);
      chk("t5b_elem", req_elem, 8'hC3);
      step(); rd_elem_valid = 1'b0; rden[0] = 1'b0;
      @(negedge clk);
      chk("t5b_no_to", req_timeout, 3'b000);
      chk("t5b_kept", gnt, 3'b001);

      // asynchronous reset while requester 2 reads
      step(); req_busy = 3'b100;
      step(2); rden[2] = 1'b1;
      @(negedge clk);
      chk("t6_gnt", gnt, 3'b100);
      chk("t6_rd_en", rd_en, 1);
      step(); #2; rst_n = 1'b0; #1;
      chk("t6_rst_gnt", gnt, 3'b000);
      chk("t6_rst_rd_en", rd_en, 0);
      req_busy = 3'b110; rden = '0;
      step(); rst_n = 1'b1;
      step(); @(negedge clk); chk("t6_after", gnt, 3'b010);

      step(2);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
